gf180mcu_fd_sc_mcu9t5v0__and2_dbnc: RTL and testbench

Clocked, glitch-filtered AND-condition detector for asynchronous A1/A2 inputs.
- Synchronises both inputs into the CLK domain.
- Forms the AND condition.
- Asserts Z only after the condition has held for a programmable number of consecutive cycles.
- Emits single-cycle edge pulses on every filtered transition.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__and2_dbnc_if.sv | 32 +++
 rtl/gf180mcu_fd_sc_mcu9t5v0__and2_dbnc.sv | 143 ++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__and2_dbnc.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__and2_dbnc_if.sv
// Signal bundle for the glitch-filtered AND detector.
// GF180MCU_FD_SC_MCU9T5V0__AND2_DBNC_STICKY_EN adds the clr/zs sticky-flag pair.
interface gf180mcu_fd_sc_mcu9t5v0__and2_dbnc_if;
  logic a1;
  logic a2;
  logic z;
  logic zr;
  logic zf;
  logic busy;
`ifdef GF180MCU_FD_SC_MCU9T5V0__AND2_DBNC_STICKY_EN
  logic clr;
  logic zs;
`endif

  modport master (
    output a1, a2,
`ifdef GF180MCU_FD_SC_MCU9T5V0__AND2_DBNC_STICKY_EN
    output clr,
    input  zs,
`endif
    input  z, zr, zf, busy
  );

  modport slave (
    input  a1, a2,
`ifdef GF180MCU_FD_SC_MCU9T5V0__AND2_DBNC_STICKY_EN
    input  clr,
    output zs,
`endif
    output z, zr, zf, busy
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__and2_dbnc.sv
// Synchronised, debounced A1&A2 detector with registered edge pulses.
// GF180MCU_FD_SC_MCU9T5V0__AND2_DBNC_STICKY_EN adds a sticky rise flag (zs) cleared by clr.
module gf180mcu_fd_sc_mcu9t5v0__and2_dbnc #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYC    = 4
) (
  input logic clk,
  input logic rn,
  gf180mcu_fd_sc_mcu9t5v0__and2_dbnc_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);
  localparam bit FAST = (FILT_CYC == 1);

  localparam logic [1:0] LO = 2'd0;
  localparam logic [1:0] QH = 2'd1;
  localparam logic [1:0] HI = 2'd2;
  localparam logic [1:0] QL = 2'd3;

  logic [SYNC_STAGES-1:0] a1_sync;
  logic [SYNC_STAGES-1:0] a2_sync;
  logic                   cond;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             z_q, zr_q, zf_q, busy_q;
  logic             z_d, zr_d, zf_d, busy_d;

  // Per-input synchroniser chains
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      a1_sync <= '0;
      a2_sync <= '0;
    end else begin
      a1_sync <= {a1_sync[SYNC_STAGES-2:0], bus.a1};
      a2_sync <= {a2_sync[SYNC_STAGES-2:0], bus.a2};
    end
  end

  assign cond = a1_sync[SYNC_STAGES-1] & a2_sync[SYNC_STAGES-1];

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      state_q <= LO;
      cnt_q   <= '0;
      z_q     <= 1'b0;
      zr_q    <= 1'b0;
      zf_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      zr_q    <= zr_d;
      zf_q    <= zf_d;
      busy_q  <= busy_d;
    end
  end

  // Next state; terminal compare precedes increment so the counter never wraps
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LO: begin
        if (cond) begin
          if (FAST) begin
            state_d = HI;
          end else begin
            state_d = QH;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      QH: begin
        if (!cond) begin
          state_d = LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HI: begin
        if (!cond) begin
          if (FAST) begin
            state_d = LO;
          end else begin
            state_d = QL;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      QL: begin
        if (cond) begin
          state_d = HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = LO;
        cnt_d   = '0;
      end
    endcase

    z_d    = (state_d == HI) || (state_d == QL);
    zr_d   = z_d & ~z_q;
    zf_d   = ~z_d & z_q;
    busy_d = (state_d == QH) || (state_d == QL);
  end

  assign bus.z    = z_q;
  assign bus.zr   = zr_q;
  assign bus.zf   = zf_q;
  assign bus.busy = busy_q;

`ifdef GF180MCU_FD_SC_MCU9T5V0__AND2_DBNC_STICKY_EN
  logic zs_q;

  // Set on the rise edge and held through the ZR cycle, so a clr overlapping the pulse loses
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      zs_q <= 1'b0;
    end else if (zr_d || zr_q) begin
      zs_q <= 1'b1;
    end else if (bus.clr) begin
      zs_q <= 1'b0;
    end
  end

  assign bus.zs = zs_q;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__and2_dbnc.sv
// Directed bench for the debounced AND detector: run-length reference model plus literal checks.
module tb_gf180mcu_fd_sc_mcu9t5v0__and2_dbnc;

  localparam int unsigned SYNC = 2;
  localparam int unsigned FILT = 4;

  logic clk = 1'b0;
  logic rn  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  gf180mcu_fd_sc_mcu9t5v0__and2_dbnc_if bus ();

  gf180mcu_fd_sc_mcu9t5v0__and2_dbnc #(.SYNC_STAGES(SYNC), .FILT_CYC(FILT)) dut (
    .clk (clk),
    .rn  (rn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: input seen SYNC edges late; z flips after FILT consecutive disagreeing samples
  logic [SYNC-1:0] hist;
  int   run;
  logic zm, zrm, zfm, busym, zsm, zr_prev, cs;

  always @(posedge clk or negedge rn) begin
    if (!rn) begin
      hist = '0; run = 0; zm = 0; zrm = 0; zfm = 0; busym = 0; zsm = 0;
    end else begin
      cs      = hist[SYNC-1];
      hist    = {hist[SYNC-2:0], bus.a1 & bus.a2};
      zr_prev = zrm;
      zrm = 0; zfm = 0;
      run = (cs != zm) ? run + 1 : 0;
      if (run == FILT) begin
        zm  = ~zm;
        zrm = zm;
        zfm = ~zm;
        run = 0;
      end
      busym = (run != 0);
`ifdef GF180MCU_FD_SC_MCU9T5V0__AND2_DBNC_STICKY_EN
      zsm = zrm | zr_prev | (zsm & ~bus.clr);
`endif
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("model_z", bus.z, zm);
      chk("model_zr", bus.zr, zrm);
      chk("model_zf", bus.zf, zfm);
      chk("model_busy", bus.busy, busym);
`ifdef GF180MCU_FD_SC_MCU9T5V0__AND2_DBNC_STICKY_EN
      chk("model_zs", bus.zs, zsm);
`endif
    end
  end

  logic zr_seen, zf_seen, z_seen, z_low;

  // Drive a2 high for len cycles, then low, watching outputs for 16 cycles
  task automatic pulse_a2(input int len);
    zr_seen = 0; zf_seen = 0; z_seen = 0; z_low = 0;
    for (int e = 0; e < 16; e++) begin
      @(negedge clk);
      bus.a2 = (e < len);
      @(posedge clk);
      #1;
      zr_seen |= bus.zr;
      zf_seen |= bus.zf;
      z_seen  |= bus.z;
      z_low   |= ~bus.z;
    end
  endtask

  initial begin
    bus.a1 = 1'b1;
    bus.a2 = 1'b1;
`ifdef GF180MCU_FD_SC_MCU9T5V0__AND2_DBNC_STICKY_EN
    bus.clr = 1'b0;
`endif
    // Reset held with inputs high: outputs stay clear
    repeat (3) @(negedge clk);
    chk("rst_z", bus.z, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_zr", bus.zr, 1'b0);

    @(negedge clk);
    rn = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      if (e == 2) chk("rel_busy_e2", bus.busy, 1'b0);
      if (e == 3) chk("rel_busy_e3", bus.busy, 1'b1);
      if (e == 5) begin chk("rel_z_e5", bus.z, 1'b0); chk("rel_busy_e5", bus.busy, 1'b1); end
      if (e == 6) begin chk("rel_z_e6", bus.z, 1'b1); chk("rel_zr_e6", bus.zr, 1'b1); chk("rel_busy_e6", bus.busy, 1'b0); end
      if (e == 7) begin chk("rel_zr_e7", bus.zr, 1'b0); chk("rel_z_e7", bus.z, 1'b1); end
    end

    // Deassert: z falls six edges later with a single zf
    @(negedge clk);
    bus.a2 = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) chk("fall_z_e5", bus.z, 1'b1);
      if (e == 6) begin chk("fall_z_e6", bus.z, 1'b0); chk("fall_zf_e6", bus.zf, 1'b1); chk("fall_zr_e6", bus.zr, 1'b0); end
      if (e == 7) chk("fall_zf_e7", bus.zf, 1'b0);
    end

    // Glitch reject: 3 cycles ignored, 4 cycles accepted
    pulse_a2(3);
    chk("glitch3_z", z_seen, 1'b0);
    chk("glitch3_zr", zr_seen, 1'b0);
    chk("glitch3_busy_end", bus.busy, 1'b0);
    pulse_a2(4);
    chk("pulse4_z", z_seen, 1'b1);
    chk("pulse4_zr", zr_seen, 1'b1);

    // Two-cycle drop while high: z holds, no zf
    @(negedge clk);
    bus.a2 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("hold_z_before", bus.z, 1'b1);
    zf_seen = 0; z_low = 0;
    for (int e = 0; e < 12; e++) begin
      @(negedge clk);
      bus.a2 = !(e == 0 || e == 1);
      @(posedge clk);
      #1;
      zf_seen |= bus.zf;
      z_low   |= ~bus.z;
    end
    chk("drop2_zf", zf_seen, 1'b0);
    chk("drop2_zlow", z_low, 1'b0);

    // Reset in the middle of qualifying high
    @(negedge clk);
    bus.a2 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.a2 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", bus.busy, 1'b1);
    #2;
    rn = 1'b0;
    #1;
    chk("mid_rst_z", bus.z, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_zr", bus.zr, 1'b0);
    chk("mid_rst_zf", bus.zf, 1'b0);
    repeat (2) @(negedge clk);
    rn = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) chk("restart_z_e5", bus.z, 1'b0);
      if (e == 6) begin chk("restart_z_e6", bus.z, 1'b1); chk("restart_zr_e6", bus.zr, 1'b1); end
    end

`ifdef GF180MCU_FD_SC_MCU9T5V0__AND2_DBNC_STICKY_EN
    chk("zs_set", bus.zs, 1'b1);
    @(negedge clk);
    bus.a2 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("zs_fell_z", bus.z, 1'b0);
    chk("zs_held", bus.zs, 1'b1);
    @(negedge clk);
    bus.clr = 1'b1;
    @(posedge clk);
    #1;
    chk("zs_clr", bus.zs, 1'b0);
    @(negedge clk);
    bus.clr = 1'b0;
    bus.a2  = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (e == 5) bus.clr = 1'b1;
      if (e == 6) begin chk("zs_race_zr", bus.zr, 1'b1); chk("zs_race_e6", bus.zs, 1'b1); end
      if (e == 7) begin chk("zs_race_e7", bus.zs, 1'b1); bus.clr = 1'b0; end
      if (e == 8) chk("zs_race_e8", bus.zs, 1'b1);
    end
`endif

    repeat (2) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
